// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Time-multiplexed controller for a 4-tap FIR. One 8x8 multiplier and an
// 18-bit accumulator are stepped over the four taps, producing one result
// per accepted sample (one sample every 5 cycles at most).
//
// Parameters:
//   C0..C3     reset values of coefficients k0..k3 (k0 multiplies the newest sample)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample this cycle (IDLE and not in reset)
//   in         8-bit unsigned sample
//   coef_we    coefficient write strobe (honoured only in IDLE)
//   coef_addr  coefficient index 0..3
//   coef_data  8-bit unsigned coefficient value
//   coef_err   one-cycle pulse when a write arrived during MAC and was dropped
//   op_valid   one-cycle pulse marking a new result on op
//   op         18-bit unsigned result, held until the next result
//   busy       high while the MAC pass is running
module fir_mac_sequencer #(
    parameter logic [7:0] C0 = 8'd1,
    parameter logic [7:0] C1 = 8'd2,
    parameter logic [7:0] C2 = 8'd3,
    parameter logic [7:0] C3 = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in,
    input  logic        coef_we,
    input  logic [1:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic        coef_err,
    output logic        op_valid,
    output logic [17:0] op,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q [4];
    logic [7:0]  x_d [4];
    logic [7:0]  k_q [4];
    logic [7:0]  k_d [4];
    logic [17:0] acc_q, acc_d;
    logic [1:0]  tap_q, tap_d;
    logic [17:0] op_q, op_d;
    logic        op_valid_q, op_valid_d;
    logic        coef_err_q, coef_err_d;

    logic        accept_s;
    logic [15:0] prod_s;
    logic [17:0] sum_s;

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q == MAC);
    assign op       = op_q;
    assign op_valid = op_valid_q;
    assign coef_err = coef_err_q;

    assign accept_s = in_valid && in_ready;

    // Single shared multiplier: the tap counter selects the coefficient/sample pair.
    assign prod_s = {8'd0, k_q[tap_q]} * {8'd0, x_q[tap_q]};
    assign sum_s  = acc_q + {2'b00, prod_s};

    // Next-state, datapath and pulse logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tap_d      = tap_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        coef_err_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_d[i] = x_q[i];
            k_d[i] = k_q[i];
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    x_d[0]  = in;
                    x_d[1]  = x_q[0];
                    x_d[2]  = x_q[1];
                    x_d[3]  = x_q[2];
                    acc_d   = 18'd0;
                    tap_d   = 2'd0;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
                // A write landing on the accept edge is seen by tap 0 one cycle later,
                // so the new coefficient applies to that very sample.
                if (coef_we) begin
                    k_d[coef_addr] = coef_data;
                end else begin
                    coef_err_d = 1'b0;
                end
            end
            MAC: begin
                acc_d = sum_s;
                tap_d = tap_q + 2'd1;
                if (tap_q == 2'd3) begin
                    op_d       = sum_s;
                    op_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d    = MAC;
                end
                // Coefficients stay frozen during a pass; report the lost write.
                if (coef_we) begin
                    coef_err_d = 1'b1;
                end else begin
                    coef_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset to the power-on values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= 18'd0;
            tap_q      <= 2'd0;
            op_q       <= 18'd0;
            op_valid_q <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= 8'd0;
            end
            k_q[0]     <= C0;
            k_q[1]     <= C1;
            k_q[2]     <= C2;
            k_q[3]     <= C3;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tap_q      <= tap_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            coef_err_q <= coef_err_d;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= x_d[i];
                k_q[i] <= k_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer with hand-computed results.
module tb_fir_mac_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_s;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_err;
    logic        op_valid;
    logic [17:0] op;
    logic        busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    fir_mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_s),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_err  (coef_err),
        .op_valid  (op_valid),
        .op        (op),
        .busy      (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance negedges until op_valid is seen, bounded to 12 cycles.
    task automatic wait_op(output int n);
        n = 0;
        while (op_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Present one sample (optionally with a same-cycle coefficient write) and check its result.
    task automatic do_sample(input string tag, input logic [7:0] v, input logic [17:0] exp_op,
                             input logic we, input logic [1:0] addr, input logic [7:0] data);
        int n;
        @(negedge clk);
        check_val({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_s      = v;
        coef_we   = we;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_val({tag, "_cerr"}, {31'd0, coef_err}, 32'd0);
        wait_op(n);
        check_val({tag, "_lat"}, n, 32'd4);
        check_val({tag, "_op"}, {14'd0, op}, {14'd0, exp_op});
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'd0, op_valid}, 32'd0);
        check_val({tag, "_hold"}, {14'd0, op}, {14'd0, exp_op});
    endtask

    task automatic write_coef(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we   = 1'b0;
        check_val("wr_idle_cerr", {31'd0, coef_err}, 32'd0);
    endtask

    logic [7:0]  b2b_in  [3] = '{8'd10, 8'd20, 8'd30};
    logic [17:0] b2b_exp [3] = '{18'd10, 18'd40, 18'd100};
    logic [17:0] fs_exp  [4] = '{18'd66810, 18'd131835, 18'd196860, 18'd260100};
    logic [17:0] imp_exp [5] = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd0};

    initial begin
        int n;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_s      = 8'd0;
        coef_we   = 1'b0;
        coef_addr = 2'd0;
        coef_data = 8'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_val("rst_op", {14'd0, op}, 32'd0);
        check_val("rst_opv", {31'd0, op_valid}, 32'd0);
        check_val("rst_cerr", {31'd0, coef_err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_rdy_in_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("rst_rdy_rel", {31'd0, in_ready}, 32'd1);

        // Impulse with default coefficients.
        for (int i = 0; i < 5; i++) begin
            do_sample("imp", (i == 0) ? 8'd1 : 8'd0, imp_exp[i], 1'b0, 2'd0, 8'd0);
        end

        // Back-to-back with in_valid held high.
        @(negedge clk);
        in_valid = 1'b1;
        in_s     = b2b_in[0];
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (s < 2) in_s = b2b_in[s + 1];
            for (int c = 0; c < 4; c++) begin
                check_val("b2b_rdy_low", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
            end
            check_val("b2b_opv", {31'd0, op_valid}, 32'd1);
            check_val("b2b_op", {14'd0, op}, {14'd0, b2b_exp[s]});
            check_val("b2b_rdy_back", {31'd0, in_ready}, 32'd1);
            if (s == 2) in_valid = 1'b0;
        end

        // Write while busy: dropped, coef_err pulses once, k2 stays 3.
        // Line becomes [5,30,20,10] -> 5 + 60 + 60 + 40 = 165.
        @(negedge clk);
        in_valid = 1'b1;
        in_s     = 8'd5;
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'd2;
        coef_data = 8'd9;
        @(negedge clk);
        coef_we = 1'b0;
        check_val("busy_wr_cerr", {31'd0, coef_err}, 32'd1);
        @(negedge clk);
        check_val("busy_wr_cerr_pulse", {31'd0, coef_err}, 32'd0);
        wait_op(n);
        check_val("busy_wr_lat", n, 32'd2);
        check_val("busy_wr_op", {14'd0, op}, 32'd165);

        // Flush the line with zeros: [0,5,30,20]=180, [0,0,5,30]=135, [0,0,0,5]=20, 0.
        do_sample("flush0", 8'd0, 18'd180, 1'b0, 2'd0, 8'd0);
        do_sample("flush1", 8'd0, 18'd135, 1'b0, 2'd0, 8'd0);
        do_sample("flush2", 8'd0, 18'd20,  1'b0, 2'd0, 8'd0);
        do_sample("flush3", 8'd0, 18'd0,   1'b0, 2'd0, 8'd0);

        // Write k0=5 on the same edge as sample 7.
        do_sample("wr_acc", 8'd7, 18'd35, 1'b1, 2'd0, 8'd5);

        // Full scale: all coefficients 255, line starts [7,0,0,0].
        for (int a = 0; a < 4; a++) write_coef(a[1:0], 8'd255);
        for (int i = 0; i < 4; i++) begin
            do_sample("fullscale", 8'd255, fs_exp[i], 1'b0, 2'd0, 8'd0);
        end

        // Reset asserted at tap 2 of a pass.
        @(negedge clk);
        in_valid = 1'b1;
        in_s     = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_op", {14'd0, op}, 32'd0);
        check_val("midrst_opv", {31'd0, op_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_rdy", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (op_valid === 1'b1) seen = 1'b1;
        end
        check_val("midrst_no_opv", {31'd0, seen}, 32'd0);

        // Impulse after reset: coefficients and line back to defaults.
        for (int i = 0; i < 4; i++) begin
            do_sample("imp_post_rst", (i == 0) ? 8'd1 : 8'd0, imp_exp[i], 1'b0, 2'd0, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
